// File: rtl/counter_pkg.sv
// Shared counter definitions: direction encodings and the per-digit width helper
// used by the counter and the seven-segment display decoders.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int digit_width(input int base);
        return $clog2(base);
    endfunction

endpackage

// File: rtl/digit_chain_counter_if.sv
// Control/status bundle of the digit chain counter; master drives commands,
// slave (the counter) returns the packed count and terminal flags.
interface digit_chain_counter_if
    import counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BASE   = 10
);
    localparam int DW = digit_width(BASE);

    logic                   clear;
    logic                   load;
    logic [DIGITS*DW-1:0]   load_value;
    logic                   enable;
    logic                   up_dn;
    logic [DIGITS*DW-1:0]   count;
    logic                   at_max;
    logic                   at_min;
    logic                   wrap;

    modport master (
        output clear, load, load_value, enable, up_dn,
        input  count, at_max, at_min, wrap
    );

    modport slave (
        input  clear, load, load_value, enable, up_dn,
        output count, at_max, at_min, wrap
    );

endinterface

// File: rtl/counter_digit.sv
// One mod-BASE digit register with clear, clamped load and a single up/down step.
module counter_digit
    import counter_pkg::*;
#(
    parameter int  BASE = 10,
    localparam int DW   = digit_width(BASE)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] load_digit,
    input  logic          step,
    input  logic          up_dn,
    output logic [DW-1:0] q,
    output logic          is_max,
    output logic          is_min
);

    localparam logic [DW-1:0] MAX_VAL = DW'(BASE - 1);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (load) begin
            // Digits outside 0..BASE-1 are clamped so the register never leaves range.
            q_d = (int'(load_digit) > BASE - 1) ? MAX_VAL : load_digit;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                q_d = (q_q == MAX_VAL) ? '0 : q_q + DW'(1);
            end else begin
                q_d = (q_q == '0) ? MAX_VAL : q_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign is_max = (q_q == MAX_VAL);
    assign is_min = (q_q == '0);

endmodule

// File: rtl/digit_chain_counter.sv
// Multi-digit mod-BASE up/down counter: combinational carry/borrow chain across
// counter_digit instances, optional saturation and a registered wrap pulse.
module digit_chain_counter
    import counter_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int BASE     = 10,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    digit_chain_counter_if.slave bus
);

    localparam int   DW  = digit_width(BASE);
    localparam logic SAT = (SATURATE != 0);

    logic [DIGITS-1:0]    dig_max;
    logic [DIGITS-1:0]    dig_min;
    logic [DIGITS-1:0]    dig_step;
    logic [DIGITS:0]      carry_up;
    logic [DIGITS:0]      carry_dn;
    logic [DIGITS*DW-1:0] count;
    logic                 at_max;
    logic                 at_min;
    logic                 terminal;
    logic                 step_en;
    logic                 wrap_q;
    logic                 wrap_d;

    assign carry_up[0] = 1'b1;
    assign carry_dn[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            // Digit gi moves only when every lower digit is at its rollover value.
            assign carry_up[gi+1] = carry_up[gi] & dig_max[gi];
            assign carry_dn[gi+1] = carry_dn[gi] & dig_min[gi];
            assign dig_step[gi]   = step_en &
                                    ((bus.up_dn == DIR_UP) ? carry_up[gi] : carry_dn[gi]);

            counter_digit #(
                .BASE (BASE)
            ) u_digit (
                .clk        (clk),
                .reset_n    (reset_n),
                .clear      (bus.clear),
                .load       (bus.load),
                .load_digit (bus.load_value[gi*DW +: DW]),
                .step       (dig_step[gi]),
                .up_dn      (bus.up_dn),
                .q          (count[gi*DW +: DW]),
                .is_max     (dig_max[gi]),
                .is_min     (dig_min[gi])
            );
        end
    endgenerate

    assign at_max   = carry_up[DIGITS];
    assign at_min   = carry_dn[DIGITS];
    assign terminal = (bus.up_dn == DIR_UP) ? at_max : at_min;

    // In saturate mode a step off the terminal value is suppressed entirely.
    assign step_en = bus.enable & ~(SAT & terminal);

    always_comb begin
        wrap_d = ~bus.clear & ~bus.load & step_en & terminal;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bus.count  = count;
    assign bus.at_max = at_max;
    assign bus.at_min = at_min;
    assign bus.wrap   = wrap_q;

endmodule

// File: doc/digit_chain_counter.md
# digit_chain_counter

Parametrised multi-digit up/down counter built from a chain of mod-BASE digits. Supports synchronous clear, parallel load, and a wrap or saturate mode at the terminal values. It drives the tic-tac-toe move timer and score displays, presenting one DW-bit field per digit for the seven-segment path. It is the successor to the single-digit mod counter: the maximum value is computed correctly, and the block adds direction, load, cascading and a registered wrap event.

## Interface
- DIGITS, default 2: number of chained digits, ≥1.
- BASE, default 10: modulus of each digit, ≥2. Digit range is 0..BASE-1.
- SATURATE, default 0: 0 selects wrap at terminal values; 1 selects hold at terminal values.
- DW: derived, not overridable. DW = $clog2(BASE) bits per digit (BASE=10 → 4, BASE=2 → 1).
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear to all-zero.
- load  in  1  synchronous parallel load of load_value.
- load_value  in  DIGITS*DW  load data. Digit i occupies bits [i*DW +: DW]; digit 0 is least significant.
- enable  in  1  count tick. Produces one step per cycle while high.
- up_dn  in  1  direction. 1 counts up, 0 counts down.
- count  out  DIGITS*DW  current value, same packing as load_value.
- at_max  out  1  combinational. High when every digit equals BASE-1.
- at_min  out  1  combinational. High when every digit equals 0.
- wrap  out  1  registered one-cycle pulse on a wrap event.

## Operation
- Priority per edge: clear > load > enable. clear wins over a simultaneous load or enable; load wins over enable. A cycle in which none of the three is asserted holds count.
- Load clamps each out-of-range digit to BASE-1. For example, with BASE=10 a digit value of 0xC loads as 9.
- Carry chain for counting up:
  - Digit 0 steps when enable is high.
  - Digit i steps when enable is high and every lower digit equals BASE-1.
  - A stepping digit at BASE-1 goes to 0; otherwise it increments.
- Carry chain for counting down:
  - Digit i steps when enable is high and every lower digit equals 0.
  - A stepping digit at 0 goes to BASE-1; otherwise it decrements.
- Terminal behaviour, SATURATE=0: up from at_max gives all-zero; down from at_min gives all-(BASE-1). Either transition sets wrap.
- Terminal behaviour, SATURATE=1: up while at_max, or down while at_min, leaves count unchanged and wrap stays 0.
- wrap is never set by clear, load, or reset.
- up_dn may change on any cycle. The step taken uses the up_dn value sampled at that edge.
- A change of BASE is not supported at run time; it is an elaboration parameter only.

## Timing
- Reset: count = 0 and wrap = 0 immediately and asynchronously. Consequently at_min = 1 and at_max = 0 during reset.
- Reset may assert mid-count. Recovery starts at the first rising edge after deassertion, from value 0.
- count updates at the rising edge that samples clear, load or enable. Latency is 1 cycle.
- wrap goes high in the same cycle that count first shows the wrapped value, and is low in the following cycle unless a second wrap occurs.
- With enable held continuously, wrap pulses every BASE^DIGITS cycles.
- at_max and at_min are decoded from the count register and have no added latency.
- The carry chain is purely combinational across digits; there is no ripple delay in cycles.

## Structure
- Shared package counter_pkg holds:
  - localparams DIR_UP = 1'b1 and DIR_DN = 1'b0;
  - a function digit_width(base), returning $clog2(base), used for DW here and in the display decoders.
- Sub-module counter_digit is one mod-BASE digit register:
  - parameter BASE;
  - inputs clk, reset_n, clear, load, load_digit, step, up_dn;
  - outputs q, is_max, is_min.
- The top-level instantiates DIGITS counter_digit instances in a generate loop. It builds the step chain from the is_max / is_min flags of lower digits and registers wrap.

## Test plan
- DIGITS=2, BASE=10, SATURATE=0. Hold up_dn=1 and enable=1 from reset for 99 cycles → count=0x99 and at_max=1. One more cycle → count=0x00, wrap=1 for exactly one cycle, at_min=1.
- Same configuration. From reset set up_dn=0 and pulse enable once → count=0x99 and wrap=1. Then step 10 times → count=0x89, and digit 1 decremented exactly once.
- Load 0x47 → count=0x47 the next cycle with wrap=0. Load 0x4C → count=0x49 (clamped). Load together with enable=1 → the loaded value is taken and no step occurs.
- SATURATE=1: load 0x01, up_dn=0, enable held 5 cycles → count=0x00 from the second cycle on, at_min=1 throughout, wrap never asserts. Then up_dn=1 → 0x01.
- Assert clear, load=1 (0x55) and enable=1 in the same cycle → count=0x00 next cycle.
- Assert reset_n low mid-count at 0x37, between clock edges → count=0x00 immediately. Deassert → counting resumes 0x01, 0x02, ….
- DIGITS=3, BASE=2: count up 8 steps → sequence 000..111 then 000 with a wrap pulse. The result matches a 3-bit binary counter.
